mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Two-master arbiter sharing the single core memory bus port (REQ/LOCK/ORDER/MASK/RW/ADDR/DATA out, VALID/BUSY/64-bit DATA back) between M0 (core data path) and M1 (instruction fetch / GCI DMA).
- Grants one master per accepted command.
- Tracks outstanding reads in an in-order ID FIFO and routes each returned VALID/DATA to the master that issued it.
- Sits between the core-side masters and the external memory model or controller.

Parameters:
- P_OUTSTANDING, 4, max in-flight reads; power of 2, from 2 to 16.
- P_ID_W, $clog2(P_OUTSTANDING), FIFO pointer width (derived; do not override).

Ports:
- iCLOCK  in  1  core clock; all logic is on the rising edge.
- inRESET  in  1  reset; synchronous, active-low.
- iMn_REQ  in  1  master n command request (n=0,1).
- oMn_LOCK  out  1  master n stall; the master holds its command stable while this is high.
- iMn_ORDER  in  2  access size: 00 byte, 01 2-byte, 10 word, 11 none.
- iMn_MASK  in  4  byte mask.
- iMn_RW  in  1  1 write, 0 read.
- iMn_ADDR  in  32  address.
- iMn_DATA  in  32  write data.
- oMn_VALID  out  1  read data valid to master n.
- iMn_BUSY  in  1  master n cannot accept read data.
- oMn_DATA  out  64  read data to master n.
- oMEMORY_REQ  out  1  request to memory.
- iMEMORY_LOCK  in  1  memory stall.
- oMEMORY_ORDER  out  2  granted ORDER.
- oMEMORY_MASK  out  4  granted MASK.
- oMEMORY_RW  out  1  granted RW.
- oMEMORY_ADDR  out  32  granted ADDR.
- oMEMORY_DATA  out  32  granted write data.
- iMEMORY_VALID  in  1  read data valid from memory.
- oMEMORY_BUSY  out  1  backpressure to memory.
- iMEMORY_DATA  in  64  read data.
- oERR_ORPHAN  out  1  sticky error: VALID arrived with no outstanding read.

Behaviour:
- Reset (inRESET=0 at posedge): FIFO empty, grant hold cleared, RR pointer = M0, oERR_ORPHAN=0. All outputs are 0 during reset, including oMn_LOCK=0.
- Command path is a combinational mux of the granted master; zero added latency.
- Accept condition: oMEMORY_REQ && !iMEMORY_LOCK.
- Grant select (no hold active): the default is fixed priority, M0 over M1.
- Grant hold: when the granted master's request was not accepted (iMEMORY_LOCK=1), a hold register keeps the same grant next cycle, even if the other master raises REQ. The hold clears on accept or on the holder dropping REQ.
- oMn_LOCK = iMn_REQ && (not granted || iMEMORY_LOCK || blocked).
- blocked = the granted command is a read (RW=0) and the FIFO is full. When blocked, oMEMORY_REQ=0.
- Writes are never blocked by FIFO full and generate no response.
- Read accept: push the granted master ID into the FIFO.
- Return path: the FIFO head ID selects the destination.
  - oMn_VALID = iMEMORY_VALID && head==n && !empty.
  - oMn_DATA = iMEMORY_DATA for both masters (unqualified).
  - oMEMORY_BUSY = iMn_BUSY of the head master; 0 if empty.
- Pop on iMEMORY_VALID && !oMEMORY_BUSY && !empty.
- Same-cycle push and pop is legal at any occupancy; count is unchanged. At full, a pop does not unblock a same-cycle read; that read is accepted the following cycle.
- iMEMORY_VALID while empty: data is dropped, no oMn_VALID, and oERR_ORPHAN sets. It clears only on reset.
- Reset mid-transaction discards all outstanding IDs. Late VALIDs after reset are orphans and set the error.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin grant. The RR pointer toggles to the other master on each accepted command. With both masters requesting, accepted commands alternate M0, M1, M0, and so on. Grant hold still applies.
- Undefined: fixed priority, M0 over M1; the RR pointer logic is absent.

Decomposition:
- Package mem_arb_pkg: ORDER encodings (BYTE=2'h0, HALF=2'h1, WORD=2'h2, NONE=2'h3) and the master ID type (1 bit).
- Sub-module mem_arb_id_fifo: synchronous FIFO of master IDs, depth P_OUTSTANDING, with full/empty/count and simultaneous push/pop support.

Test Plan:
1. Single M0 read, addr 0x0000_1000, memory returns 0x1122334455667788 after 3 cycles -> oM0_VALID for 1 cycle with that data; oM1_VALID stays 0; FIFO empty afterwards.
2. M0 and M1 both request reads in the same cycle, fixed priority -> M0 accepted first, M1 accepted next cycle. Returns in order reach M0 then M1. With MEM_ARB_ROUND_ROBIN_EN and continuous requests, grants alternate for 8 commands.
3. iMEMORY_LOCK high 5 cycles while M1 is granted and M0 then raises REQ -> grant held on M1, oM0_LOCK=1; M1's command is accepted when LOCK drops.
4. P_OUTSTANDING=4: issue 4 reads with no returns, then a 5th read and a write to 0x0002_0000 -> read stalled with oMEMORY_REQ=0; write accepted; the 5th read is accepted the cycle after the first return pops.
5. Head master is M1 with iM1_BUSY=1 for 3 cycles -> oMEMORY_BUSY=1, no pop; data is delivered when BUSY drops.
6. iMEMORY_VALID with FIFO empty -> no master VALID, oERR_ORPHAN=1 and it stays set until inRESET=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory bus arbiter.
// Provides ORDER encodings, the master ID type and the command payload struct.
package mem_arb_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RDATA_W = 64;
    localparam int unsigned MASK_W  = 4;

    typedef enum logic [1:0] {
        ORDER_BYTE = 2'h0,
        ORDER_HALF = 2'h1,
        ORDER_WORD = 2'h2,
        ORDER_NONE = 2'h3
    } order_e;

    typedef logic master_id_t;

    localparam master_id_t ID_M0 = 1'b0;
    localparam master_id_t ID_M1 = 1'b1;

    typedef struct packed {
        order_e              order;
        logic [MASK_W-1:0]   mask;
        logic                rw;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
    } cmd_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of master IDs for outstanding reads.
// Ports: iCLOCK/inRESET (sync active-low), i_push/i_push_id write side,
//        i_pop read side, o_head current head ID, o_full/o_empty status.
// Push and pop in the same cycle leave the occupancy unchanged.
import mem_arb_pkg::*;

module mem_arb_id_fifo #(
    parameter int unsigned P_DEPTH = 4,
    parameter int unsigned P_ID_W  = $clog2(P_DEPTH)
) (
    input  logic       iCLOCK,
    input  logic       inRESET,
    input  logic       i_push,
    input  master_id_t i_push_id,
    input  logic       i_pop,
    output master_id_t o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int unsigned CNT_W = P_ID_W + 1;

    master_id_t         r_mem [P_DEPTH];
    logic [P_ID_W-1:0]  r_wr_ptr;
    logic [P_ID_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // Pointers and occupancy; pointers wrap naturally since depth is a power of 2.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + P_ID_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + P_ID_W'(1);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // ID storage; contents are don't-care while empty.
    always_ff @(posedge iCLOCK) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_id;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(P_DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared core memory bus port.
// Ports: iCLOCK/inRESET (sync active-low); iM0_*/oM0_* and iM1_*/oM1_* master
//        command and return channels; oMEMORY_*/iMEMORY_* memory side;
//        oERR_ORPHAN sticky flag for a read return with nothing outstanding.
// Command path is a zero-latency mux of the granted master. Read returns are
// routed in order using an ID FIFO. All outputs are forced to 0 during reset.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin grant instead of
// fixed priority (M0 over M1).
import mem_arb_pkg::*;

module mem_bus_arbiter #(
    parameter int unsigned P_OUTSTANDING = 4,
    parameter int unsigned P_ID_W        = $clog2(P_OUTSTANDING)
) (
    input  logic                iCLOCK,
    input  logic                inRESET,
    input  logic                iM0_REQ,
    output logic                oM0_LOCK,
    input  logic [1:0]          iM0_ORDER,
    input  logic [MASK_W-1:0]   iM0_MASK,
    input  logic                iM0_RW,
    input  logic [ADDR_W-1:0]   iM0_ADDR,
    input  logic [DATA_W-1:0]   iM0_DATA,
    output logic                oM0_VALID,
    input  logic                iM0_BUSY,
    output logic [RDATA_W-1:0]  oM0_DATA,
    input  logic                iM1_REQ,
    output logic                oM1_LOCK,
    input  logic [1:0]          iM1_ORDER,
    input  logic [MASK_W-1:0]   iM1_MASK,
    input  logic                iM1_RW,
    input  logic [ADDR_W-1:0]   iM1_ADDR,
    input  logic [DATA_W-1:0]   iM1_DATA,
    output logic                oM1_VALID,
    input  logic                iM1_BUSY,
    output logic [RDATA_W-1:0]  oM1_DATA,
    output logic                oMEMORY_REQ,
    input  logic                iMEMORY_LOCK,
    output logic [1:0]          oMEMORY_ORDER,
    output logic [MASK_W-1:0]   oMEMORY_MASK,
    output logic                oMEMORY_RW,
    output logic [ADDR_W-1:0]   oMEMORY_ADDR,
    output logic [DATA_W-1:0]   oMEMORY_DATA,
    input  logic                iMEMORY_VALID,
    output logic                oMEMORY_BUSY,
    input  logic [RDATA_W-1:0]  iMEMORY_DATA,
    output logic                oERR_ORPHAN
);

    logic       r_hold_vld;
    master_id_t r_hold_id;
    logic       r_err_orphan;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    master_id_t r_rr_ptr;
`endif

    cmd_t       w_cmd0, w_cmd1, w_cmd, w_cmd_out;
    master_id_t w_sel;
    logic       w_req_gnt, w_blocked, w_mem_req, w_accept, w_push, w_pop;
    logic       w_fifo_full, w_fifo_empty, w_head_busy;
    master_id_t w_head;

    assign w_cmd0 = '{order: order_e'(iM0_ORDER), mask: iM0_MASK, rw: iM0_RW,
                      addr: iM0_ADDR, data: iM0_DATA};
    assign w_cmd1 = '{order: order_e'(iM1_ORDER), mask: iM1_MASK, rw: iM1_RW,
                      addr: iM1_ADDR, data: iM1_DATA};

    // Grant select: an active hold wins while its holder still requests.
    always_comb begin
        w_sel = ID_M0;
        if (r_hold_vld && ((r_hold_id == ID_M1) ? iM1_REQ : iM0_REQ))
            w_sel = r_hold_id;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        else if (iM0_REQ && iM1_REQ)
            w_sel = r_rr_ptr;
`endif
        else if (!iM0_REQ && iM1_REQ)
            w_sel = ID_M1;
    end

    assign w_req_gnt = (w_sel == ID_M1) ? iM1_REQ : iM0_REQ;
    assign w_cmd     = (w_sel == ID_M1) ? w_cmd1 : w_cmd0;
    // Full is the registered occupancy, so a same-cycle pop never unblocks a read.
    assign w_blocked = !w_cmd.rw && w_fifo_full;
    assign w_mem_req = inRESET && w_req_gnt && !w_blocked;
    assign w_accept  = w_mem_req && !iMEMORY_LOCK;
    assign w_push    = w_accept && !w_cmd.rw;

    assign w_head_busy = (w_head == ID_M1) ? iM1_BUSY : iM0_BUSY;
    assign w_pop       = inRESET && iMEMORY_VALID && !w_fifo_empty && !w_head_busy;

    // Hold the grant across a memory stall; drops on accept or request withdrawal.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            r_hold_vld <= 1'b0;
            r_hold_id  <= ID_M0;
        end else begin
            r_hold_vld <= w_req_gnt && iMEMORY_LOCK;
            r_hold_id  <= w_sel;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Round-robin pointer moves to the other master after every accept.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET)      r_rr_ptr <= ID_M0;
        else if (w_accept) r_rr_ptr <= ~w_sel;
    end
`endif

    // Sticky orphan-return flag.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET)                          r_err_orphan <= 1'b0;
        else if (iMEMORY_VALID && w_fifo_empty) r_err_orphan <= 1'b1;
    end

    mem_arb_id_fifo #(
        .P_DEPTH (P_OUTSTANDING),
        .P_ID_W  (P_ID_W)
    ) u_id_fifo (
        .iCLOCK    (iCLOCK),
        .inRESET   (inRESET),
        .i_push    (w_push),
        .i_push_id (w_sel),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign w_cmd_out     = inRESET ? w_cmd : '0;
    assign oMEMORY_REQ   = w_mem_req;
    assign oMEMORY_ORDER = w_cmd_out.order;
    assign oMEMORY_MASK  = w_cmd_out.mask;
    assign oMEMORY_RW    = w_cmd_out.rw;
    assign oMEMORY_ADDR  = w_cmd_out.addr;
    assign oMEMORY_DATA  = w_cmd_out.data;

    assign oM0_LOCK = inRESET && iM0_REQ && ((w_sel != ID_M0) || iMEMORY_LOCK || w_blocked);
    assign oM1_LOCK = inRESET && iM1_REQ && ((w_sel != ID_M1) || iMEMORY_LOCK || w_blocked);

    assign oM0_VALID    = inRESET && iMEMORY_VALID && !w_fifo_empty && (w_head == ID_M0);
    assign oM1_VALID    = inRESET && iMEMORY_VALID && !w_fifo_empty && (w_head == ID_M1);
    assign oM0_DATA     = inRESET ? iMEMORY_DATA : '0;
    assign oM1_DATA     = inRESET ? iMEMORY_DATA : '0;
    assign oMEMORY_BUSY = inRESET && !w_fifo_empty && w_head_busy;
    assign oERR_ORPHAN  = r_err_orphan;

endmodule
